mux_l2_rr_arbiter: RTL and testbench
====================================

# mux_l2_rr_arbiter

Two-lane round-robin arbiter that sits in front of the L2 2-to-1 mux stage and shares its single 8-bit output path between lane 0 and lane 1. Each lane is buffered in a small FIFO. A scheduler grants one lane per cycle. The granted word is moved into a registered output stage with valid/ready backpressure, and the `selector` value that steers the mux is produced with it.

## Interface
- `DATA_W`, default 8: data width per lane and on output.
- `DEPTH`, default 4: entries per lane FIFO; power of two, ≥2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in0` input DATA_W: lane 0 data.
- `valid_bit0` input 1: lane 0 word present.
- `ready0` output 1: lane 0 can accept a word; equals not-full of FIFO 0.
- `in1` input DATA_W: lane 1 data.
- `valid_bit1` input 1: lane 1 word present.
- `ready1` output 1: lane 1 can accept a word; equals not-full of FIFO 1.
- `data_out` output DATA_W: registered granted word.
- `valid_out` output 1: `data_out` holds a word.
- `ready_out` input 1: downstream accepts `data_out` this cycle.
- `selector` output 1: lane that `data_out` came from; 0 means lane 0.

## Operation
- Push: lane k writes when `valid_bit_k` && `ready_k`. Data offered while `ready_k`=0 is ignored, and the source must hold it.
- `ready_k` depends only on the FIFO count. When full, `ready_k`=0 even if a pop occurs in the same cycle (conservative, no combinational path).
- The output stage loads when `valid_out`=0 or `ready_out`=1.
- Grant rule when the output stage loads:
  - both FIFOs non-empty: grant lane = NOT `last_grant`;
  - one non-empty: grant that lane;
  - none: `valid_out` goes to 0 and `data_out`/`selector` hold.
- On grant:
  - pop the FIFO head into `data_out`;
  - set `valid_out`=1;
  - `selector` = granted lane;
  - `last_grant` = granted lane.
- Stall: while `valid_out`=1 and `ready_out`=0, `data_out`, `selector` and `valid_out` stay stable. No pop occurs and `last_grant` is unchanged.
- Fairness: with both lanes continuously backlogged and `ready_out`=1, grants strictly alternate 0,1,0,1…
- Ordering: each lane's words exit in FIFO order. Inter-lane order is set only by the grant rule.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Simultaneous push and pop on the same non-full FIFO: the count is unchanged and both actions take effect.
- Reset (any cycle, including mid-transfer or mid-stall) flushes both FIFOs and drops the word in the output stage.

## Timing
- Reset values:
  - `valid_out`=0, `data_out`=0, `selector`=0;
  - `last_grant`=1, so lane 0 wins the first tie;
  - FIFO counts and pointers 0, so `ready0`=`ready1`=1 the cycle after reset.
- While `reset`=1, both `ready_k` are forced to 0 and pushes are ignored.
- Latency:
  - a word pushed at edge E into an empty system, with an idle output, appears with `valid_out`=1 after edge E+1;
  - that is one cycle of FIFO plus one of the output register.
- Throughput: one word per cycle while any FIFO is non-empty and `ready_out`=1.
- Handshake completes at a rising edge where `valid_out`=1 && `ready_out`=1. A new word, or `valid_out`=0, is visible after that same edge.
- `ready_k` falls the cycle after the push that fills FIFO k. It rises the cycle after the pop that frees an entry.

## Structure
- Shared package `mux_l2_pkg`:
  - `DATA_W`, `DEPTH`, derived `PTR_W`;
  - lane-id constants `LANE0`=0 and `LANE1`=1.
- Sub-module `lane_fifo` (synchronous FIFO, same clock/reset, push/pop/full/empty/count), instantiated once per lane.
- The top level holds the grant logic, the `last_grant` register and the output register.

## Test plan
- Reset and first tie:
  - after reset, push `in0`=0x01 and `in1`=0x02 in the same cycle, `ready_out`=1;
  - → `data_out` sequence 0x01 (`selector`=0), then 0x02 (`selector`=1);
  - `valid_out` first high 2 edges after the push.
- Alternation:
  - preload lane 0 with 0x0A,0x05,0xFF and lane 1 with 0x0B,0x06,0xAA;
  - → outputs 0x0A,0x0B,0x05,0x06,0xFF,0xAA with `selector` 0,1,0,1,0,1.
- Backpressure and full:
  - hold `ready_out`=0, stream lane 0 words 0x10..0x14;
  - → `ready0` drops after 5 words (4 in FIFO + 1 in the output register);
  - `data_out`=0x10 stable throughout the stall;
  - releasing `ready_out` drains 0x10..0x14 in order.
- Single-lane bypass: only lane 1 active with 0x09, 0xA2 → both granted back-to-back with `selector`=1 and no idle cycle.
- Wrap-around: push and pop 10 words continuously on lane 0 (pointers wrap twice) → output order 0 through 9 intact, with no loss or duplication.
- Mid-operation reset:
  - assert `reset` for 1 cycle while `valid_out`=1 and both FIFOs hold 2 words;
  - → next cycle `valid_out`=0, `data_out`=0, `selector`=0, `ready0`=`ready1`=1;
  - no pre-reset word ever appears.

Source files
------------

// File: rtl/mux_l2_pkg.sv
// Shared parameters and lane identifiers for the L2 two-lane round-robin arbiter.
package mux_l2_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO: power-of-two depth, pointers wrap naturally, count 0..Depth.
module lane_fifo #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             pop_i,
  output logic [DataW-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o && !rst_i;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mux_l2_rr_arbiter.sv
// Two-lane round-robin arbiter feeding the L2 2-to-1 mux: lane FIFOs, grant logic and a
// registered valid/ready output stage carrying the mux selector.
module mux_l2_rr_arbiter #(
  parameter int unsigned DATA_W = mux_l2_pkg::DATA_W,
  parameter int unsigned DEPTH  = mux_l2_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic              valid_bit0,
  output logic              ready0,
  input  logic [DATA_W-1:0] in1,
  input  logic              valid_bit1,
  output logic              ready1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic              selector
);

  import mux_l2_pkg::*;

  logic [DATA_W-1:0] rdata0, rdata1;
  logic              full0, full1, empty0, empty1;
  logic              push0, push1, pop0, pop1;

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              selector_q, selector_d;
  logic              last_grant_q, last_grant_d;
  logic              grant;

  assign ready0 = !full0 && !reset;
  assign ready1 = !full1 && !reset;
  assign push0  = valid_bit0 && ready0;
  assign push1  = valid_bit1 && ready1;

  lane_fifo #(
    .DataW(DATA_W),
    .Depth(DEPTH)
  ) u_fifo0 (
    .clk_i  (clk),
    .rst_i  (reset),
    .push_i (push0),
    .wdata_i(in0),
    .pop_i  (pop0),
    .rdata_o(rdata0),
    .full_o (full0),
    .empty_o(empty0)
  );

  lane_fifo #(
    .DataW(DATA_W),
    .Depth(DEPTH)
  ) u_fifo1 (
    .clk_i  (clk),
    .rst_i  (reset),
    .push_i (push1),
    .wdata_i(in1),
    .pop_i  (pop1),
    .rdata_o(rdata1),
    .full_o (full1),
    .empty_o(empty1)
  );

  always_comb begin
    data_out_d   = data_out_q;
    valid_out_d  = valid_out_q;
    selector_d   = selector_q;
    last_grant_d = last_grant_q;
    pop0         = 1'b0;
    pop1         = 1'b0;
    grant        = LANE0;

    // Output stage loads when empty or being drained this cycle.
    if (!valid_out_q || ready_out) begin
      if (!empty0 && !empty1) begin
        grant = ~last_grant_q;
      end else if (!empty0) begin
        grant = LANE0;
      end else begin
        grant = LANE1;
      end

      if (empty0 && empty1) begin
        valid_out_d = 1'b0;
      end else begin
        valid_out_d  = 1'b1;
        selector_d   = grant;
        last_grant_d = grant;
        if (grant == LANE0) begin
          data_out_d = rdata0;
          pop0       = 1'b1;
        end else begin
          data_out_d = rdata1;
          pop1       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      selector_q   <= LANE0;
      last_grant_q <= LANE1;
    end else begin
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      selector_q   <= selector_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign selector  = selector_q;

endmodule

// File: tb/tb_mux_l2_rr_arbiter.sv
// Self-checking bench for mux_l2_rr_arbiter: vector table, directed corner cases and a
// randomized run against a queue-based reference model.
module tb_mux_l2_rr_arbiter;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in0, in1;
  logic          valid_bit0, valid_bit1;
  logic          ready0, ready1;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_out;
  logic          selector;

  always #5 clk = ~clk;

  mux_l2_rr_arbiter #(
    .DATA_W(DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in0       (in0),
    .valid_bit0(valid_bit0),
    .ready0    (ready0),
    .in1       (in1),
    .valid_bit1(valid_bit1),
    .ready1    (ready1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .selector  (selector)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: one queue per lane plus the output register contents.
  logic [DW-1:0] m_q0[$];
  logic [DW-1:0] m_q1[$];
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic          m_sel   = 1'b0;
  logic          m_last  = 1'b1;

  // Handshakes observed on the DUT output.
  logic [DW-1:0] obs_d[$];
  logic          obs_s[$];
  int            obs_c[$];
  logic [DW-1:0] exp_d[$];
  logic          exp_s[$];

  typedef struct {
    logic          rst;
    logic [DW-1:0] d0;
    logic          v0;
    logic [DW-1:0] d1;
    logic          v1;
    logic          ro;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_sel;
    logic          e_r0;
    logic          e_r1;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic r0, r1, g, any;
    r0 = !reset && (m_q0.size() < DEPTH);
    r1 = !reset && (m_q1.size() < DEPTH);
    if (!reset && valid_out === 1'b1 && ready_out) begin
      obs_d.push_back(data_out);
      obs_s.push_back(selector);
      obs_c.push_back(cyc);
    end
    @(posedge clk);
    if (reset) begin
      m_q0.delete();
      m_q1.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 1'b0;
      m_last  = 1'b1;
    end else begin
      if (!m_valid || ready_out) begin
        any = (m_q0.size() > 0) || (m_q1.size() > 0);
        if (m_q0.size() > 0 && m_q1.size() > 0) g = !m_last;
        else g = (m_q0.size() == 0);
        if (!any) begin
          m_valid = 1'b0;
        end else begin
          m_valid = 1'b1;
          m_sel   = g;
          m_last  = g;
          m_data  = g ? m_q1.pop_front() : m_q0.pop_front();
        end
      end
      if (valid_bit0 && r0) m_q0.push_back(in0);
      if (valid_bit1 && r1) m_q1.push_back(in1);
    end
    cyc++;
    #1;
    check("model_valid_out", 32'(valid_out), 32'(m_valid));
    check("model_data_out", 32'(data_out), 32'(m_data));
    check("model_selector", 32'(selector), 32'(m_sel));
    check("model_ready0", 32'(ready0), 32'(!reset && (m_q0.size() < DEPTH)));
    check("model_ready1", 32'(ready1), 32'(!reset && (m_q1.size() < DEPTH)));
  endtask

  task automatic idle_inputs();
    valid_bit0 = 1'b0;
    valid_bit1 = 1'b0;
    in0        = '0;
    in1        = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    ready_out = 1'b1;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    obs_d.delete();
    obs_s.delete();
    obs_c.delete();
  endtask

  // Drains with ready_out=1 until exp_d has been seen, then checks order and no extras.
  task automatic drain_expect(input string name, input int max_cyc);
    int n;
    idle_inputs();
    ready_out = 1'b1;
    n = 0;
    while (obs_d.size() < exp_d.size() && n < max_cyc) begin
      tick();
      n++;
    end
    tick();
    tick();
    check({name, "_count"}, 32'(obs_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < obs_d.size()) begin
        check({name, "_data"}, 32'(obs_d[i]), 32'(exp_d[i]));
        check({name, "_sel"}, 32'(obs_s[i]), 32'(exp_s[i]));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 8'h01, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    // Reset state and first tie.
    reset_dut();
    check("reset_valid_out", 32'(valid_out), 32'(0));
    check("reset_data_out", 32'(data_out), 32'(0));
    check("reset_ready0", 32'(ready0), 32'(1));
    check("reset_ready1", 32'(ready1), 32'(1));
    for (int i = 0; i < 5; i++) begin
      reset      = vecs[i].rst;
      in0        = vecs[i].d0;
      valid_bit0 = vecs[i].v0;
      in1        = vecs[i].d1;
      valid_bit1 = vecs[i].v1;
      ready_out  = vecs[i].ro;
      tick();
      check("vec_valid_out", 32'(valid_out), 32'(vecs[i].e_valid));
      check("vec_data_out", 32'(data_out), 32'(vecs[i].e_data));
      check("vec_selector", 32'(selector), 32'(vecs[i].e_sel));
      check("vec_ready0", 32'(ready0), 32'(vecs[i].e_r0));
      check("vec_ready1", 32'(ready1), 32'(vecs[i].e_r1));
    end
    reset = 1'b0;

    // Alternation from a preloaded state.
    reset_dut();
    ready_out = 1'b0;
    in0 = 8'h0A; in1 = 8'h0B; valid_bit0 = 1'b1; valid_bit1 = 1'b1; tick();
    in0 = 8'h05; in1 = 8'h06; tick();
    in0 = 8'hFF; in1 = 8'hAA; tick();
    exp_d = '{8'h0A, 8'h0B, 8'h05, 8'h06, 8'hFF, 8'hAA};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    drain_expect("alternate", 20);

    // Backpressure until lane 0 is full.
    reset_dut();
    ready_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready0_open", 32'(ready0), 32'(1));
      in0 = 8'(8'h10 + i);
      valid_bit0 = 1'b1;
      tick();
    end
    check("bp_ready0_full", 32'(ready0), 32'(0));
    in0 = 8'h15;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_stall_data", 32'(data_out), 32'(8'h10));
      check("bp_stall_valid", 32'(valid_out), 32'(1));
    end
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    drain_expect("backpressure", 20);

    // Single-lane back-to-back grants.
    reset_dut();
    in1 = 8'h09; valid_bit1 = 1'b1; tick();
    in1 = 8'hA2; tick();
    exp_d = '{8'h09, 8'hA2};
    exp_s = '{1'b1, 1'b1};
    drain_expect("bypass", 10);
    if (obs_c.size() >= 2) check("bypass_gap", 32'(obs_c[1] - obs_c[0]), 32'(1));

    // Pointer wrap-around on lane 0.
    reset_dut();
    exp_d.delete();
    exp_s.delete();
    for (int i = 0; i < 10; i++) begin
      in0 = 8'(i);
      valid_bit0 = 1'b1;
      tick();
      exp_d.push_back(8'(i));
      exp_s.push_back(1'b0);
    end
    drain_expect("wrap", 20);

    // Reset while output is held and both FIFOs hold two words.
    reset_dut();
    ready_out = 1'b0;
    in0 = 8'h31; in1 = 8'h32; valid_bit0 = 1'b1; valid_bit1 = 1'b1; tick();
    in0 = 8'h33; in1 = 8'h34; tick();
    in0 = 8'h35; valid_bit1 = 1'b0; tick();
    check("midrst_pre_valid", 32'(valid_out), 32'(1));
    idle_inputs();
    reset = 1'b1;
    tick();
    check("midrst_valid", 32'(valid_out), 32'(0));
    check("midrst_data", 32'(data_out), 32'(0));
    check("midrst_sel", 32'(selector), 32'(0));
    reset = 1'b0;
    #1;
    check("midrst_ready0", 32'(ready0), 32'(1));
    check("midrst_ready1", 32'(ready1), 32'(1));
    obs_d.delete();
    ready_out = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("midrst_no_stale", 32'(obs_d.size()), 32'(0));

    // Randomized traffic against the model.
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      in0        = 8'($urandom);
      in1        = 8'($urandom);
      valid_bit0 = ($urandom_range(0, 2) != 0);
      valid_bit1 = ($urandom_range(0, 2) != 0);
      ready_out  = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
